// File: rtl/rs_syndrome_seq.sv
// RS(15,9) syndrome calculator over GF(2^4), poly x^4 + x + 1.
// Horner evaluation of S1..S6 through one time-shared GF multiplier.
module rs_syndrome_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [23:0] out_syn,
    output logic        out_err,
    output logic        out_valid,
    input  logic        out_ready
);

    // state | meaning
    // IDLE  | waiting for the next received symbol
    // CALC  | one Horner step per syndrome, j_cnt = 0..5
    // OUT   | syndrome vector presented until out_ready
    localparam int N    = 15;
    localparam int NSYN = 6;

    typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;

    state_t      state, state_nxt;
    logic [3:0]  sym_reg;
    logic [3:0]  sym_cnt;
    logic [2:0]  j_cnt;
    logic [3:0]  syn [NSYN];
    logic [3:0]  mul_a, mul_b, mul_p;
    logic        last_j;

    function automatic logic [3:0] gf_mult(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p ^ (7'(a) << i);
        for (int i = 6; i >= 4; i--)
            if (p[i]) p = p ^ (7'b0010011 << (i - 4));
        return p[3:0];
    endfunction

    // Accumulator operand is zeroed on r14 so a new codeword needs no clear pass.
    always_comb begin
        mul_a = syn[0];
        mul_b = 4'h2;
        case (j_cnt)
            3'd0: begin mul_a = syn[0]; mul_b = 4'h2; end
            3'd1: begin mul_a = syn[1]; mul_b = 4'h4; end
            3'd2: begin mul_a = syn[2]; mul_b = 4'h8; end
            3'd3: begin mul_a = syn[3]; mul_b = 4'h3; end
            3'd4: begin mul_a = syn[4]; mul_b = 4'h6; end
            3'd5: begin mul_a = syn[5]; mul_b = 4'hC; end
            default: begin mul_a = syn[0]; mul_b = 4'h2; end
        endcase
        if (sym_cnt == 4'd0)
            mul_a = 4'h0;
    end

    assign mul_p  = gf_mult(mul_a, mul_b);
    assign last_j = (j_cnt == 3'(NSYN - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (last_j) state_nxt = (sym_cnt == 4'(N - 1)) ? OUT : IDLE;
            OUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            sym_reg <= '0;
            sym_cnt <= '0;
            j_cnt   <= '0;
            for (int i = 0; i < NSYN; i++)
                syn[i] <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sym_reg <= in_data;
                        j_cnt   <= '0;
                    end
                end
                CALC: begin
                    for (int i = 0; i < NSYN; i++)
                        if (j_cnt == 3'(i))
                            syn[i] <= mul_p ^ sym_reg;
                    if (last_j) begin
                        j_cnt   <= '0;
                        sym_cnt <= (sym_cnt == 4'(N - 1)) ? 4'd0 : sym_cnt + 4'd1;
                    end else begin
                        j_cnt <= j_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_syn   = {syn[5], syn[4], syn[3], syn[2], syn[1], syn[0]};
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = rst_n && (state == OUT);
    assign out_err   = rst_n && (|out_syn);

endmodule

// File: tb/tb_rs_syndrome_seq.sv
// Directed bench for rs_syndrome_seq: vector table of codewords plus
// hand-written latency, back-pressure and reset sequences.
module tb_rs_syndrome_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] out_syn;
    logic        out_err;
    logic        out_valid;
    logic        out_ready;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int cyc      = 0;
    int last_acc = -1;
    int min_gap  = 1000;
    int max_gap  = 0;

    typedef struct {
        logic [59:0] cw;       // cw[59:56] = r14, sent first
        logic [23:0] exp_syn;
        logic        exp_err;
        int          max_gap;
    } vec_t;

    vec_t vecs [6];

    rs_syndrome_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_syn   (out_syn),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst_n && in_valid && in_ready) begin
            if (last_acc >= 0) begin
                if (cyc - last_acc < min_gap) min_gap = cyc - last_acc;
                if (cyc - last_acc > max_gap) max_gap = cyc - last_acc;
            end
            last_acc = cyc;
        end
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_gaps();
        last_acc = -1;
        min_gap  = 1000;
        max_gap  = 0;
    endtask

    task automatic send_sym(input logic [3:0] d, input int gap);
        int n;
        @(negedge clk);
        repeat (gap) @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 24'(in_ready), 24'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_cw(input logic [59:0] cw, input int maxgap, input int count);
        for (int i = 0; i < count; i++)
            send_sym(cw[59 - 4*i -: 4], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
    endtask

    task automatic wait_out(input string name, input logic [23:0] exp_syn, input logic exp_err,
                            input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk({name, "_out_valid_timeout"}, 24'(out_valid), 24'd1);
        chk({name, "_syn"}, out_syn, exp_syn);
        chk({name, "_err"}, 24'(out_err), 24'(exp_err));
        if (hold > 0) begin
            in_data  = 4'hF;
            in_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk({name, "_hold_valid"}, 24'(out_valid), 24'd1);
                chk({name, "_hold_syn"}, out_syn, exp_syn);
                chk({name, "_hold_in_ready"}, 24'(in_ready), 24'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_in_ready_after"}, 24'(in_ready), 24'd1);
        chk({name, "_out_valid_after"}, 24'(out_valid), 24'd0);
    endtask

    initial begin
        vecs[0] = '{cw: 60'h0,                   exp_syn: 24'h000000, exp_err: 1'b0, max_gap: 0};
        vecs[1] = '{cw: 60'h100000000000000,     exp_syn: 24'hA7EFD9, exp_err: 1'b1, max_gap: 0};
        vecs[2] = '{cw: 60'h000000000000001,     exp_syn: 24'h111111, exp_err: 1'b1, max_gap: 0};
        vecs[3] = '{cw: 60'h100000000000001,     exp_syn: 24'hB6FEC8, exp_err: 1'b1, max_gap: 0};
        vecs[4] = '{cw: 60'h200000000000000,     exp_syn: 24'h7EFD91, exp_err: 1'b1, max_gap: 0};
        vecs[5] = '{cw: 60'h000000000000010,     exp_syn: 24'hC63842, exp_err: 1'b1, max_gap: 0};

        rst_n     = 1'b0;
        in_data   = 4'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 24'(in_ready), 24'd1);
        chk("reset_out_valid", 24'(out_valid), 24'd0);
        chk("reset_out_syn", out_syn, 24'h0);
        chk("reset_out_err", 24'(out_err), 24'd0);

        // First codeword also checks output latency after the last accept.
        clear_gaps();
        send_cw(vecs[1].cw, 0, 15);
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("lat_before", 24'(out_valid), 24'd0);
        @(negedge clk);
        chk("lat_at", 24'(out_valid), 24'd1);
        chk("b2b_min_gap", 24'(min_gap), 24'd7);
        chk("b2b_max_gap", 24'(max_gap), 24'd7);
        wait_out("lat_cw", vecs[1].exp_syn, vecs[1].exp_err, 0);

        for (int v = 0; v < 6; v++) begin
            send_cw(vecs[v].cw, vecs[v].max_gap, 15);
            wait_out($sformatf("vec%0d", v), vecs[v].exp_syn, vecs[v].exp_err, 0);
        end

        // Random in_valid gaps must not change the result.
        clear_gaps();
        send_cw(vecs[3].cw, 4, 15);
        chk("gap_min_gap", 24'(min_gap >= 7), 24'd1);
        wait_out("gapped", vecs[3].exp_syn, vecs[3].exp_err, 0);

        // Back-pressure: out_ready held low for 10 cycles.
        send_cw(vecs[1].cw, 0, 15);
        wait_out("hold", vecs[1].exp_syn, vecs[1].exp_err, 10);

        // Reset after 7 symbols discards the partial codeword.
        send_cw(60'h1A5000000000000, 0, 7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_comb_in_ready", 24'(in_ready), 24'd0);
        chk("rst_comb_out_valid", 24'(out_valid), 24'd0);
        chk("rst_comb_out_err", 24'(out_err), 24'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_syn", out_syn, 24'h0);
        rst_n = 1'b1;
        send_cw(vecs[1].cw, 0, 15);
        wait_out("post_rst", vecs[1].exp_syn, vecs[1].exp_err, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
